// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch stage for the 16-bit core. It owns the program counter,
// keeps at most one word read outstanding to instruction memory, and presents
// a registered IF/ID instruction word to decode. Stall holds the stage,
// Redirect flushes it, and a one-entry skid buffer catches a response that
// returns while decode is stalled.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       synchronous active-low reset
//   ImemReq     read request to instruction memory
//   ImemAddr    word address of the request (the PC)
//   ImemGnt     memory accepted the request this cycle
//   ImemRvalid  read data valid (one per grant, at least a cycle later)
//   ImemRdata   read data
//   Stall       decode cannot accept a new instruction
//   Redirect    taken branch/jump: flush and refetch from RedirectPC
//   RedirectPC  redirect target word address
//   InstrValid  Instr/InstrPC hold a live instruction
//   Instr       registered instruction word
//   InstrPC     word address Instr was fetched from
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ImemReq,
  output logic [15:0] ImemAddr,
  input  logic        ImemGnt,
  input  logic        ImemRvalid,
  input  logic [15:0] ImemRdata,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [15:0] RedirectPC,
  output logic        InstrValid,
  output logic [15:0] Instr,
  output logic [15:0] InstrPC
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]  state;
  logic [15:0] pc;
  logic [15:0] req_pc;
  logic        buf_valid;
  logic [15:0] buf_instr;
  logic [15:0] buf_pc;

  logic        granted;
  logic        rsp_live;
  logic        rsp_to_out;

  // No new request while the skid buffer is occupied, so the buffer can never
  // be asked to hold a second word.
  assign ImemReq    = rst_n && (state == S_REQ) && !buf_valid;
  assign ImemAddr   = pc;
  assign granted    = ImemReq && ImemGnt;
  assign rsp_live   = (state == S_WAIT) && ImemRvalid;
  assign rsp_to_out = rsp_live && (!InstrValid || !Stall);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      req_pc     <= RESET_PC;
      InstrValid <= 1'b0;
      Instr      <= 16'h0000;
      InstrPC    <= 16'h0000;
      buf_valid  <= 1'b0;
      buf_instr  <= 16'h0000;
      buf_pc     <= 16'h0000;
    end else if (Redirect) begin
      // Flush: anything granted but not yet returned must be swallowed in DROP.
      pc         <= RedirectPC;
      InstrValid <= 1'b0;
      buf_valid  <= 1'b0;
      case (state)
        S_REQ:   if (granted) state <= S_DROP;
        S_WAIT:  state <= ImemRvalid ? S_REQ : S_DROP;
        S_DROP:  if (ImemRvalid) state <= S_REQ;
        default: state <= S_REQ;
      endcase
    end else begin
      // Fetch control
      case (state)
        S_REQ: begin
          if (granted) begin
            req_pc <= pc;
            pc     <= pc + 16'd1;
            state  <= S_WAIT;
          end
        end
        S_WAIT:  if (ImemRvalid) state <= S_REQ;
        S_DROP:  if (ImemRvalid) state <= S_REQ;
        default: state <= S_REQ;
      endcase

      // IF/ID register and skid buffer
      if (rsp_to_out) begin
        InstrValid <= 1'b1;
        Instr      <= ImemRdata;
        InstrPC    <= req_pc;
      end else if (rsp_live) begin
        buf_valid <= 1'b1;
        buf_instr <= ImemRdata;
        buf_pc    <= req_pc;
      end else if (InstrValid && !Stall) begin
        if (buf_valid) begin
          Instr     <= buf_instr;
          InstrPC   <= buf_pc;
          buf_valid <= 1'b0;
        end else begin
          InstrValid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Bench for fetch_unit: a cycle table with a hand-driven memory, hand-written
// sequences for the stalled-redirect and wrap/reset corners (second instance
// with RESET_PC=FFFF), then randomized memory timing, stalls and redirects
// checked against a stream-level model of delivered instructions.
module tb_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, gnt, rv, stall, redir;
  logic [15:0] rdata, rpc;
  logic        req, iv;
  logic [15:0] addr, instr, ipc;
  logic        w_req, w_iv;
  logic [15:0] w_addr, w_instr, w_ipc;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .ImemReq(req), .ImemAddr(addr), .ImemGnt(gnt),
    .ImemRvalid(rv), .ImemRdata(rdata), .Stall(stall), .Redirect(redir),
    .RedirectPC(rpc), .InstrValid(iv), .Instr(instr), .InstrPC(ipc)
  );

  fetch_unit #(.RESET_PC(16'hFFFF)) dut_w (
    .clk(clk), .rst_n(rst_n), .ImemReq(w_req), .ImemAddr(w_addr), .ImemGnt(gnt),
    .ImemRvalid(rv), .ImemRdata(rdata), .Stall(stall), .Redirect(redir),
    .RedirectPC(rpc), .InstrValid(w_iv), .Instr(w_instr), .InstrPC(w_ipc)
  );

  typedef struct {
    logic        rst_n, gnt, rv;
    logic [15:0] rdata;
    logic        stall, redir;
    logic [15:0] rpc;
    logic        req;
    logic [15:0] addr;
    logic        iv;
    logic [15:0] instr, ipc;
  } vec_t;

  vec_t tbl[22];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic g, input logic v, input logic [15:0] d,
                       input logic s, input logic rd, input logic [15:0] p);
    rst_n = r; gnt = g; rv = v; rdata = d; stall = s; redir = rd; rpc = p;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic r, input logic g, input logic v, input logic [15:0] d,
                              input logic s, input logic rd, input logic [15:0] p,
                              input logic e_req, input logic [15:0] e_addr, input logic e_iv,
                              input logic [15:0] e_instr, input logic [15:0] e_ipc);
    vec_t t;
    t.rst_n = r; t.gnt = g; t.rv = v; t.rdata = d; t.stall = s; t.redir = rd; t.rpc = p;
    t.req = e_req; t.addr = e_addr; t.iv = e_iv; t.instr = e_instr; t.ipc = e_ipc;
    return t;
  endfunction

  // Random-phase model state
  logic        pending;
  logic [15:0] pend_addr;
  int          cnt;
  logic [15:0] exp_pc;
  logic        p_redir, p_freeze;
  logic [15:0] p_instr, p_ipc;
  int          delivered;
  logic        g, v, s, r;
  logic [15:0] d, p;

  initial begin
    // Each row: inputs for this cycle, then outputs expected during it.
    tbl[0]  = mk(0,0,0,16'h0000,0,0,16'h0000, 0,16'h0000,0,16'h0000,16'h0000);
    tbl[1]  = mk(1,1,0,16'h0000,0,0,16'h0000, 1,16'h0000,0,16'h0000,16'h0000);
    tbl[2]  = mk(1,0,1,16'hA5A5,0,0,16'h0000, 0,16'h0001,0,16'h0000,16'h0000);
    tbl[3]  = mk(1,1,0,16'h0000,0,0,16'h0000, 1,16'h0001,1,16'hA5A5,16'h0000);
    tbl[4]  = mk(1,0,1,16'hA5A4,0,0,16'h0000, 0,16'h0002,0,16'hA5A5,16'h0000);
    tbl[5]  = mk(1,0,0,16'h0000,0,0,16'h0000, 1,16'h0002,1,16'hA5A4,16'h0001);
    tbl[6]  = mk(1,0,0,16'h0000,0,0,16'h0000, 1,16'h0002,0,16'hA5A4,16'h0001);
    tbl[7]  = mk(1,0,0,16'h0000,0,0,16'h0000, 1,16'h0002,0,16'hA5A4,16'h0001);
    tbl[8]  = mk(1,1,0,16'h0000,0,0,16'h0000, 1,16'h0002,0,16'hA5A4,16'h0001);
    tbl[9]  = mk(1,0,1,16'hA5A7,0,0,16'h0000, 0,16'h0003,0,16'hA5A4,16'h0001);
    tbl[10] = mk(1,1,0,16'h0000,1,0,16'h0000, 1,16'h0003,1,16'hA5A7,16'h0002);
    tbl[11] = mk(1,0,1,16'hA5A6,1,0,16'h0000, 0,16'h0004,1,16'hA5A7,16'h0002);
    tbl[12] = mk(1,1,0,16'h0000,1,0,16'h0000, 0,16'h0004,1,16'hA5A7,16'h0002);
    tbl[13] = mk(1,1,0,16'h0000,0,0,16'h0000, 0,16'h0004,1,16'hA5A7,16'h0002);
    tbl[14] = mk(1,1,0,16'h0000,0,0,16'h0000, 1,16'h0004,1,16'hA5A6,16'h0003);
    tbl[15] = mk(1,0,0,16'h0000,0,1,16'h0040, 0,16'h0005,0,16'hA5A6,16'h0003);
    tbl[16] = mk(1,0,1,16'hA5A1,0,0,16'h0000, 0,16'h0040,0,16'hA5A6,16'h0003);
    tbl[17] = mk(1,1,0,16'h0000,0,0,16'h0000, 1,16'h0040,0,16'hA5A6,16'h0003);
    tbl[18] = mk(1,0,1,16'hA5E5,0,0,16'h0000, 0,16'h0041,0,16'hA5A6,16'h0003);
    tbl[19] = mk(1,0,0,16'h0000,0,0,16'h0000, 1,16'h0041,1,16'hA5E5,16'h0040);
    tbl[20] = mk(0,0,0,16'h0000,0,0,16'h0000, 0,16'h0041,0,16'hA5E5,16'h0040);
    tbl[21] = mk(1,0,0,16'h0000,0,0,16'h0000, 1,16'h0000,0,16'h0000,16'h0000);

    drive(0,0,0,16'h0000,0,0,16'h0000);
    tick; tick; tick;

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].rst_n, tbl[i].gnt, tbl[i].rv, tbl[i].rdata,
            tbl[i].stall, tbl[i].redir, tbl[i].rpc);
      #1;
      chk($sformatf("row%0d_req", i),   {15'd0, req}, {15'd0, tbl[i].req});
      chk($sformatf("row%0d_addr", i),  addr,         tbl[i].addr);
      chk($sformatf("row%0d_iv", i),    {15'd0, iv},  {15'd0, tbl[i].iv});
      chk($sformatf("row%0d_instr", i), instr,        tbl[i].instr);
      chk($sformatf("row%0d_ipc", i),   ipc,          tbl[i].ipc);
      tick;
    end

    // Redirect while stalled with the skid buffer full.
    drive(1,1,0,16'h0000,0,0,16'h0000); tick;
    drive(1,0,1,16'hA5A5,0,0,16'h0000); tick;
    drive(1,1,0,16'h0000,1,0,16'h0000); tick;
    drive(1,0,1,16'hA5A4,1,0,16'h0000); tick;
    drive(1,1,1'b0,16'h0000,1,1,16'h0123); #1;
    chk("buf_req_blocked", {15'd0, req}, 16'd0);
    chk("buf_iv_held", {15'd0, iv}, 16'd1);
    chk("buf_instr_held", instr, 16'hA5A5);
    tick;
    drive(1,1,0,16'h0000,0,0,16'h0000); #1;
    chk("redir_iv_clear", {15'd0, iv}, 16'd0);
    chk("redir_req", {15'd0, req}, 16'd1);
    chk("redir_addr", addr, 16'h0123);
    tick;
    drive(1,0,1,16'hA486,0,0,16'h0000); tick;
    drive(1,0,0,16'h0000,0,0,16'h0000); #1;
    chk("redir_first_iv", {15'd0, iv}, 16'd1);
    chk("redir_first_instr", instr, 16'hA486);
    chk("redir_first_ipc", ipc, 16'h0123);
    tick;

    // RESET_PC=FFFF: wrap to 0000, then reset while a request is outstanding.
    drive(0,0,0,16'h0000,0,0,16'h0000); tick; tick;
    drive(1,1,0,16'h0000,0,0,16'h0000); #1;
    chk("wrap_req0", {15'd0, w_req}, 16'd1);
    chk("wrap_addr0", w_addr, 16'hFFFF);
    tick;
    drive(1,0,1,16'h5A5A,0,0,16'h0000); #1;
    chk("wrap_pc_next", w_addr, 16'h0000);
    tick;
    drive(1,1,0,16'h0000,0,0,16'h0000); #1;
    chk("wrap_iv0", {15'd0, w_iv}, 16'd1);
    chk("wrap_instr0", w_instr, 16'h5A5A);
    chk("wrap_ipc0", w_ipc, 16'hFFFF);
    chk("wrap_addr1", w_addr, 16'h0000);
    tick;
    drive(1,0,1,16'hA5A5,0,0,16'h0000); tick;
    drive(1,1,0,16'h0000,0,0,16'h0000); #1;
    chk("wrap_instr1", w_instr, 16'hA5A5);
    chk("wrap_ipc1", w_ipc, 16'h0000);
    chk("wrap_addr2", w_addr, 16'h0001);
    tick;
    drive(0,0,0,16'h0000,0,0,16'h0000); #1;
    chk("rst_req_low", {15'd0, w_req}, 16'd0);
    tick;
    drive(1,0,0,16'h0000,0,0,16'h0000); #1;
    chk("rst_iv", {15'd0, w_iv}, 16'd0);
    chk("rst_instr", w_instr, 16'h0000);
    chk("rst_ipc", w_ipc, 16'h0000);
    chk("rst_req", {15'd0, w_req}, 16'd1);
    chk("rst_addr", w_addr, 16'hFFFF);
    tick;

    // Randomized memory timing, stalls and redirects on the RESET_PC=0 instance.
    drive(0,0,0,16'h0000,0,0,16'h0000); tick; tick;
    pending = 1'b0; pend_addr = 16'h0000; cnt = 0; exp_pc = 16'h0000;
    p_redir = 1'b0; p_freeze = 1'b0; p_instr = 16'h0000; p_ipc = 16'h0000;
    delivered = 0;
    for (int c = 0; c < 3000; c++) begin
      if (p_redir) begin
        chk("rnd_flush_iv", {15'd0, iv}, 16'd0);
      end else if (p_freeze) begin
        chk("rnd_freeze_iv", {15'd0, iv}, 16'd1);
        chk("rnd_freeze_instr", instr, p_instr);
        chk("rnd_freeze_ipc", ipc, p_ipc);
      end
      if (pending) chk("rnd_single_outstanding", {15'd0, req}, 16'd0);

      v = pending && (cnt == 0);
      d = v ? (pend_addr ^ 16'hA5A5) : 16'($urandom);
      g = req && ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 29) == 0);
      p = 16'($urandom);
      drive(1, g, v, d, s, r, p);
      #1;

      // Decode consumes a live instruction at this edge unless flushed.
      if (r) begin
        exp_pc = p;
      end else if (iv && !s) begin
        chk("rnd_ipc_order", ipc, exp_pc);
        chk("rnd_instr_data", instr, ipc ^ 16'hA5A5);
        exp_pc = ipc + 16'd1;
        delivered++;
      end
      p_redir  = r;
      p_freeze = iv && s && !r;
      p_instr  = instr;
      p_ipc    = ipc;

      if (v) pending = 1'b0;
      else if (pending) cnt--;
      if (g) begin
        pending   = 1'b1;
        pend_addr = addr;
        cnt       = $urandom_range(0, 2);
      end
      tick;
    end
    chk("rnd_progress", {15'd0, delivered > 200}, 16'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the 16-bit core. It owns the program counter, issues single-outstanding word reads to instruction memory, and presents a registered IF/ID instruction word to decode. Decode passes Instr[15:11] to the control decoder and Instr[10:0] to the immediate generator. Stall holds the stage and Redirect flushes it; a one-entry skid buffer absorbs a response that arrives while decode is stalled.

## Interface
- RESET_PC, 16'h0000, word address of the first fetch after reset.
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- ImemReq  output  1  read request to instruction memory.
- ImemAddr  output  16  word address of the request.
- ImemGnt  input  1  memory accepted the request this cycle.
- ImemRvalid  input  1  read data valid. Exactly one per grant, at least 1 cycle after the grant cycle.
- ImemRdata  input  16  read data, valid when ImemRvalid=1.
- Stall  input  1  decode cannot accept a new instruction.
- Redirect  input  1  branch or jump taken; flush and refetch.
- RedirectPC  input  16  target word address, sampled when Redirect=1.
- InstrValid  output  1  Instr/InstrPC hold a live instruction.
- Instr  output  16  registered instruction word.
- InstrPC  output  16  word address Instr was fetched from.

## Operation
- Registers:
  - PC: next fetch address.
  - ReqPC: address of the outstanding request.
  - Output register: InstrValid, Instr, InstrPC.
  - Skid buffer: BufValid, BufInstr, BufPC.
  - FSM state.
- FSM states:
  - REQ: may issue a request.
  - WAIT: a granted request is outstanding.
  - DROP: a granted request is outstanding and its response will be discarded.
- Outputs:
  - ImemReq = (state==REQ) && !BufValid.
  - ImemAddr = PC.
- REQ with ImemReq && ImemGnt: ReqPC<=PC, PC<=PC+1 (16-bit wrap, FFFF->0000), go to WAIT.
- REQ with ImemReq and no ImemGnt: ImemReq stays high and ImemAddr stays stable until the grant.
- WAIT with ImemRvalid, go to REQ and route {ImemRdata, ReqPC} as follows:
  - to the output register if !InstrValid || !Stall;
  - otherwise to the skid buffer.
- Output register update when no response is being written to it:
  - InstrValid && !Stall && BufValid: output<=buffer, BufValid<=0.
  - InstrValid && !Stall && !BufValid: InstrValid<=0.
  - InstrValid && Stall: hold all output bits.
- Invariant: the buffer only fills with no request outstanding, and no request issues while BufValid=1.
- Redirect has priority over Stall and over every other update in the same cycle:
  - PC<=RedirectPC; InstrValid<=0; BufValid<=0.
  - REQ, no grant: stay in REQ; the ungranted request is abandoned and the next cycle presents RedirectPC. Memory must tolerate this.
  - REQ with grant: go to DROP.
  - WAIT, no rvalid: go to DROP.
  - WAIT with rvalid: discard the data, go to REQ.
  - DROP: stay in DROP; PC takes the newest target.
- DROP with ImemRvalid: discard the data, go to REQ. Redirect in the same cycle still updates PC.
- Instr and InstrPC keep their old values when InstrValid is cleared. Consumers qualify them with InstrValid.

## Timing
- Reset (rst_n=0 at an edge) takes priority over everything, including mid-request:
  - PC=RESET_PC, state=REQ, InstrValid=0, Instr=16'h0000, InstrPC=16'h0000, BufValid=0.
  - ImemReq is 0 while rst_n=0.
  - Any response in flight after reset is the memory's responsibility to squash; the block ignores ImemRvalid in REQ.
- First ImemReq=1 appears in the first cycle with rst_n=1.
- Latency: grant at cycle N, rvalid at N+k, so InstrValid=1 from N+k+1.
- Throughput with zero-wait memory (gnt same cycle, rvalid next cycle): one instruction per 2 cycles.
- Redirect at cycle N: InstrValid=0 at N+1. ImemAddr=RedirectPC at N+1 if the state was REQ and not granted, otherwise the cycle after the discarded response.
- Stall is sampled only while InstrValid=1. A stall lasting M cycles freezes the outputs for M cycles.

## Test plan
- Reset, zero-wait memory returning Rdata = address XOR 16'hA5A5 -> ImemAddr 0,1,2,… on alternate cycles; InstrValid pulses with Instr=A5A5,A5A4,… and InstrPC=0,1,…
- ImemGnt low for 3 cycles -> ImemReq and ImemAddr held constant for 3 cycles; PC advances only on the grant.
- Stall=1 for 5 cycles starting while InstrValid=1 -> outputs frozen; next response lands in the buffer; ImemReq=0 while BufValid=1; on release, buffer moves to output with no instruction lost or duplicated.
- Redirect to 16'h0040 while in WAIT -> the late response is discarded; the next ImemAddr is 0040; the first valid InstrPC is 0040.
- Redirect asserted together with Stall and BufValid=1 -> InstrValid=0 and BufValid=0 next cycle; fetch resumes at RedirectPC.
- RESET_PC=16'hFFFF -> fetches FFFF then 0000, and InstrPC wraps correctly; rst_n pulsed low while in WAIT -> outputs return to reset values and fetch restarts at RESET_PC.
